// File: rtl/pwm_nonoverlap.sv
// pwm_nonoverlap: dead-time non-overlapping gate drive from a PWM pair; define NONOVERLAP_FAULT_EN for the sticky complementarity fault
module pwm_nonoverlap #(
  parameter int DEAD_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              PWM_sig,
  input  logic              PWM_sig_n,
  input  logic [DEAD_W-1:0] dead,
  output logic              highOut,
  output logic              lowOut,
  output logic              fault
);
`ifdef NONOVERLAP_FAULT_EN
  typedef enum logic [2:0] {IDLE, DEAD, HIGH, LOW, FLT} state_t;
`else
  typedef enum logic [1:0] {IDLE, DEAD, HIGH, LOW} state_t;
`endif
  state_t            r_state, w_next;
  logic              r_pwm_q, r_tgt, w_tgt, w_change, w_high, w_low;
  logic [DEAD_W-1:0] r_cnt, w_cnt, w_d;
  assign w_change = PWM_sig != r_pwm_q;
  assign w_d      = (dead == '0) ? DEAD_W'(1) : dead;
`ifdef NONOVERLAP_FAULT_EN
  logic r_mis, r_fault, w_mis;
  assign w_mis = PWM_sig == PWM_sig_n;
  assign fault = r_fault;
  // remember last edge's pair equality and latch the fault alongside the state
  always_ff @(posedge clk)
    if (rst) begin
      r_mis   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_mis   <= w_mis;
      r_fault <= w_next == FLT;
    end
`else
  logic w_unused;
  assign w_unused = PWM_sig_n;
  assign fault    = 1'b0;
`endif
  // state, interval counter, target side and outputs all update together
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_pwm_q <= 1'b0;
      r_tgt   <= 1'b0;
      r_cnt   <= '0;
      highOut <= 1'b0;
      lowOut  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pwm_q <= PWM_sig;
      r_tgt   <= w_tgt;
      r_cnt   <= w_cnt;
      highOut <= w_high;
      lowOut  <= w_low;
    end
  // any PWM change opens a fresh both-off interval; the counter expires on reaching 1 so it never wraps
  always_comb begin
    w_next = r_state;
    w_tgt  = r_tgt;
    w_cnt  = '0;
    case (r_state)
      IDLE: if (en) begin
        w_next = DEAD;
        w_tgt  = PWM_sig;
        w_cnt  = w_d;
      end
      DEAD: if (w_change) begin
        w_tgt = PWM_sig;
        w_cnt = w_d;
      end else if (r_cnt == DEAD_W'(1)) w_next = r_tgt ? HIGH : LOW;
      else w_cnt = r_cnt - DEAD_W'(1);
      HIGH: if (w_change) begin
        w_next = DEAD;
        w_tgt  = 1'b0;
        w_cnt  = w_d;
      end
      LOW: if (w_change) begin
        w_next = DEAD;
        w_tgt  = 1'b1;
        w_cnt  = w_d;
      end
      default: w_next = r_state;
    endcase
`ifdef NONOVERLAP_FAULT_EN
    if (r_state != FLT && w_mis && r_mis) begin
      w_next = FLT;
      w_cnt  = '0;
    end
`endif
    if (!en) begin
      w_next = IDLE;
      w_cnt  = '0;
    end
  end
  // gate enables decode the next state so they register with it and can never overlap
  always_comb begin
    w_high = w_next == HIGH;
    w_low  = w_next == LOW;
  end
endmodule

// File: tb/tb_pwm_nonoverlap.sv
// tb_pwm_nonoverlap: scoreboard bench with an interval-based reference model for pwm_nonoverlap
module tb_pwm_nonoverlap;
  localparam int DW = 6;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, p = 1'b0, pn = 1'b1;
  logic [DW-1:0] dead = '0;
  logic hi, lo, flt;
  int total = 0, bad = 0;
  logic [2:0] q[$];
  logic m_prev_p = 1'b0, m_prev_eq = 1'b0, m_run = 1'b0, m_flt = 1'b0, m_lvl = 1'b0;
  int m_cyc = 0, m_st = 0, m_d = 1;

  always #5 clk = ~clk;

  pwm_nonoverlap #(.DEAD_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .PWM_sig(p), .PWM_sig_n(pn),
    .dead(dead), .highOut(hi), .lowOut(lo), .fault(flt)
  );

  // Model: an interval starts at the first enabled edge or any edge where PWM changes;
  // the side chosen by the level at that start is driven once max(dead,1) edges have elapsed.
  task automatic step(input logic r, input logic e, input logic s, input logic sn, input logic [DW-1:0] d);
    logic eh, el;
    @(negedge clk);
    rst = r; en = e; p = s; pn = sn; dead = d;
    m_cyc++;
    if (r) begin
      m_prev_p = 1'b0; m_prev_eq = 1'b0; m_run = 1'b0; m_flt = 1'b0;
      q.push_back(3'b000);
      return;
    end
`ifdef NONOVERLAP_FAULT_EN
    m_flt = e && (m_flt || (s == sn && m_prev_eq));
`endif
    if (!e) m_run = 1'b0;
    else if (!m_run || s != m_prev_p) begin
      m_run = 1'b1; m_lvl = s; m_st = m_cyc; m_d = (d == '0) ? 1 : int'(d);
    end
    eh = !m_flt && m_run && (m_cyc - m_st >= m_d) && m_lvl;
    el = !m_flt && m_run && (m_cyc - m_st >= m_d) && !m_lvl;
    m_prev_p = s;
    m_prev_eq = (s == sn);
    q.push_back({eh, el, m_flt});
  endtask

  task automatic hold(input logic e, input logic s, input int n, input logic [DW-1:0] d);
    repeat (n) step(1'b0, e, s, ~s, d);
  endtask

  task automatic chk(input string n, input int c, input logic a, input logic x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", n, c, a, x);
    end
  endtask

  initial begin
    logic [2:0] ex;
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex = q.pop_front();
        c++;
        chk("highOut", c, hi, ex[2]);
        chk("lowOut", c, lo, ex[1]);
        chk("fault", c, flt, ex[0]);
        chk("overlap", c, hi & lo, 1'b0);
      end
    end
  end

  initial begin
    logic s, r, e, sn;
    logic [DW-1:0] d;
    int left;
    step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0);
    hold(1, 0, 12, 8); hold(1, 1, 12, 8); hold(1, 0, 12, 8);
    hold(1, 1, 3, 0); hold(1, 0, 3, 0); hold(1, 1, 1, 0); hold(1, 0, 4, 0);
    hold(1, 1, 3, 8); hold(1, 0, 15, 8);
    hold(1, 1, 2, 8); step(1, 1, 1, 0, 8); hold(1, 1, 12, 8);
    hold(0, 1, 3, 8); hold(1, 1, 12, 8);
    step(0, 1, 1, 1, 8); step(0, 1, 1, 1, 8); hold(1, 1, 6, 8); hold(0, 1, 2, 8);
    hold(1, 1, 10, 8); step(0, 1, 1, 1, 8); hold(1, 1, 6, 8);
    step(1, 0, 0, 1, 5); hold(0, 0, 3, 5); hold(1, 0, 2100, 5);
    s = 1'b0;
    left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (left == 0) begin s = ~s; left = $urandom_range(1, 20); end
      left--;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 79) != 0);
      sn = ($urandom_range(0, 29) == 0) ? s : ~s;
      d = DW'($urandom_range(0, 12));
      step(r, e, s, sn, d);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_nonoverlap.md
# pwm_nonoverlap

Dead-time gate-drive generator sitting directly downstream of the 11-bit PWM generator. Consumes the complementary `PWM_sig`/`PWM_sig_n` pair and produces high-side and low-side gate enables that are never asserted together. Every output transition is separated by a programmable both-off interval, so the power stage cannot shoot through. An optional checker latches a fault when the input pair loses complementarity.

## Interface
- `DEAD_W`, 6: width of the dead-time count (clock cycles).

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  drive enable; 0 forces both outputs off.
- `PWM_sig`  in  1  PWM from the upstream generator; 1 requests the high side.
- `PWM_sig_n`  in  1  complement of `PWM_sig`; used only by the fault checker.
- `dead`  in  DEAD_W  dead time in clocks; sampled when an interval starts.
- `highOut`  out  1  high-side gate enable, registered.
- `lowOut`  out  1  low-side gate enable, registered.
- `fault`  out  1  sticky complementarity fault, registered.

## Operation
- Effective dead time: D = max(`dead`, 1). `dead`=0 still yields 1 both-off cycle.
- A 1-bit register `pwm_q` holds the last sampled `PWM_sig`. A "change" is `PWM_sig` != `pwm_q` at a rising edge.
- FSM states:
  - IDLE: both outputs 0. Leaves to DEAD when `en`=1, with target = `PWM_sig`.
  - DEAD: both outputs 0; counter runs D cycles.
    - A change during DEAD reloads the counter from the current `dead` and updates the target (restarts the interval).
    - At expiry: target 1 goes to HIGH, target 0 goes to LOW.
  - HIGH: `highOut`=1, `lowOut`=0. A change goes to DEAD with target 0.
  - LOW: `lowOut`=1, `highOut`=0. A change goes to DEAD with target 1.
  - FAULT: only with the macro; see Configuration.
- `en`=0 in any non-FAULT state goes to IDLE, with both outputs 0 at the same edge.
- Invariant: `highOut` & `lowOut` == 0 on every cycle, including the reset cycle.
- Counter is DEAD_W bits and never wraps. It holds at zero outside DEAD.

## Timing
- Reset values: `highOut`=0, `lowOut`=0, `fault`=0, state IDLE, `pwm_q`=0, counter 0.
- `rst` wins over every other input on the same edge. Asserting it mid-DEAD or mid-HIGH/LOW drops both outputs at that edge.
- The change is sampled at edge k. The outgoing enable drops at edge k, so it is low after that edge.
- The incoming enable rises at edge k+D, giving exactly D cycles with both outputs low.
- `en` rise is sampled at edge k (from IDLE). Both outputs stay 0 through edge k+D−1; the target side asserts at edge k+D.
- A constant `PWM_sig` (duty 0 or duty max upstream) holds LOW or HIGH indefinitely once the first interval ends.
- A `PWM_sig` pulse shorter than D cycles keeps the FSM in DEAD. The output reflects the level present when the last interval expires.

## Configuration
- `NONOVERLAP_FAULT_EN` defined:
  - `PWM_sig` == `PWM_sig_n` on 2 consecutive sampled edges moves to FAULT at the 2nd edge.
  - In FAULT: both outputs 0 and `fault`=1.
  - FAULT is left only by `rst`, or by `en`=0, which goes to IDLE and clears `fault`.
  - A single-cycle mismatch is ignored.
- Undefined: `PWM_sig_n` unused, `fault` tied to 0, FAULT state absent.

## Test plan
- **Basic edge:** `dead`=8, `en`=1, `PWM_sig` 0→1 sampled at edge k.
  - `lowOut` 0 at k; both 0 for edges k..k+7; `highOut` 1 at k+8.
  - Mirror check for 1→0.
- **Zero dead time:** `dead`=0, `PWM_sig` toggle.
  - Exactly 1 both-off cycle; the new side asserts at k+1.
- **Toggle during DEAD:** `dead`=8, toggle at k, toggle back at k+3.
  - Interval restarts; both 0 through k+10; original side reasserts at k+11.
  - Overlap never occurs on any cycle.
- **Constant input (duty 0):** `PWM_sig`=0, `en` rises at k, `dead`=5.
  - `lowOut`=1 from k+5 onward; `highOut` stays 0 for 2048 cycles.
- **Reset and enable drop:**
  - `rst` asserted at k+2 of an 8-cycle DEAD: both 0 and IDLE from k+2.
  - `en`=0 while HIGH: `highOut` 0 at the next edge.
- **Fault (macro on):** `PWM_sig`=`PWM_sig_n`=1 for 2 edges.
  - `fault`=1, both outputs 0, held until `en`=0.
  - A 1-edge mismatch leaves `fault`=0.
  - With the macro off, `fault` stays 0 throughout.
